// File: rtl/riscv_pc_gen_if.sv
// Fetch-side bus of the next-PC generator: resolve/trap inputs and fetch/redirect outputs.
// Signal directions are named from the PC generator's side (i_ into it, o_ out of it).
interface riscv_pc_gen_if #(
  parameter int XLEN = 32
);
  logic            i_stall;
  logic            i_trap_valid;
  logic [XLEN-1:0] i_trap_vec;
  logic            i_res_valid;
  logic [2:0]      i_res_branch_op;
  logic            i_res_taken;
  logic [XLEN-1:0] i_res_pc;
  logic [XLEN-1:0] i_res_imm;
  logic [XLEN-1:0] i_res_rs1;
  logic            i_res_pred_taken;
  logic [XLEN-1:0] i_res_pred_target;
  logic [XLEN-1:0] o_fetch_pc;
  logic            o_fetch_pred_taken;
  logic [XLEN-1:0] o_fetch_pred_target;
  logic            o_redirect;
  logic            o_target_misalign;

  modport master (
    output i_stall, i_trap_valid, i_trap_vec, i_res_valid, i_res_branch_op, i_res_taken,
           i_res_pc, i_res_imm, i_res_rs1, i_res_pred_taken, i_res_pred_target,
    input  o_fetch_pc, o_fetch_pred_taken, o_fetch_pred_target, o_redirect, o_target_misalign
  );

  modport slave (
    input  i_stall, i_trap_valid, i_trap_vec, i_res_valid, i_res_branch_op, i_res_taken,
           i_res_pc, i_res_imm, i_res_rs1, i_res_pred_taken, i_res_pred_target,
    output o_fetch_pc, o_fetch_pred_taken, o_fetch_pred_target, o_redirect, o_target_misalign
  );
endinterface

// File: rtl/riscv_pc_gen.sv
// Next-PC generator for the fetch stage: resolves JAL/JALR/branches, traps and redirects.
// Define RISCV_PC_BTB_EN to add a direct-mapped branch target buffer predicting at fetch.
module riscv_pc_gen #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 16
) (
  input  logic           clk,
  input  logic           rst,
  riscv_pc_gen_if.slave  bus
);
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] w_next_pc;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_is_br;
  logic [XLEN-1:0] w_sum_pc;
  logic [XLEN-1:0] w_sum_rs1;
  logic [XLEN-1:0] w_target;
  logic            w_act_taken;
  logic [XLEN-1:0] w_act_next;
  logic            w_misalign;
  logic            w_mispredict;
  logic            w_redirect_res;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;

  assign w_is_jal    = (bus.i_res_branch_op == 3'b001);
  assign w_is_jalr   = (bus.i_res_branch_op == 3'b010);
  assign w_is_br     = bus.i_res_branch_op[2];
  assign w_sum_pc    = bus.i_res_pc + bus.i_res_imm;
  assign w_sum_rs1   = bus.i_res_rs1 + bus.i_res_imm;
  assign w_target    = w_is_jalr ? {w_sum_rs1[XLEN-1:1], 1'b0} : w_sum_pc;
  assign w_act_taken = w_is_jal | w_is_jalr | (w_is_br & bus.i_res_taken);
  assign w_act_next  = w_act_taken ? w_target : (bus.i_res_pc + XLEN'(4));

  assign w_misalign   = bus.i_res_valid & w_act_taken & w_target[1];
  assign w_mispredict = bus.i_res_valid &
                        ((w_act_taken != bus.i_res_pred_taken) |
                         (w_act_taken & (w_target != bus.i_res_pred_target)));
  // A misaligned target never redirects; the trap unit follows up with trap_valid.
  assign w_redirect_res = w_mispredict & ~w_misalign;

  always_comb begin
    w_next_pc = r_fetch_pc + XLEN'(4);
    if (bus.i_trap_valid)    w_next_pc = bus.i_trap_vec;
    else if (w_redirect_res) w_next_pc = w_act_next;
    else if (bus.i_stall)    w_next_pc = r_fetch_pc;
    else if (w_pred_taken)   w_next_pc = w_pred_target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fetch_pc <= RESET_PC;
    else     r_fetch_pc <= w_next_pc;
  end

`ifdef RISCV_PC_BTB_EN
  localparam int IDXW = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;

  logic [BTB_ENTRIES-1:0] r_btb_valid;
  logic [TAGW-1:0]        r_btb_tag [BTB_ENTRIES];
  logic [XLEN-1:0]        r_btb_tgt [BTB_ENTRIES];
  logic [1:0]             r_btb_cnt [BTB_ENTRIES];

  logic [IDXW-1:0] w_f_idx;
  logic [TAGW-1:0] w_f_tag;
  logic            w_f_hit;
  logic [IDXW-1:0] w_u_idx;
  logic [TAGW-1:0] w_u_tag;
  logic            w_u_hit;
  logic            w_u_en;
  logic [1:0]      w_cnt_cur;
  logic [1:0]      w_cnt_inc;
  logic [1:0]      w_cnt_dec;

  assign w_f_idx       = r_fetch_pc[IDXW+1:2];
  assign w_f_tag       = r_fetch_pc[XLEN-1:IDXW+2];
  assign w_f_hit       = r_btb_valid[w_f_idx] & (r_btb_tag[w_f_idx] == w_f_tag);
  assign w_pred_taken  = w_f_hit & r_btb_cnt[w_f_idx][1];
  assign w_pred_target = w_pred_taken ? r_btb_tgt[w_f_idx] : '0;

  assign w_u_idx   = bus.i_res_pc[IDXW+1:2];
  assign w_u_tag   = bus.i_res_pc[XLEN-1:IDXW+2];
  assign w_u_hit   = r_btb_valid[w_u_idx] & (r_btb_tag[w_u_idx] == w_u_tag);
  assign w_u_en    = bus.i_res_valid & ~w_misalign;
  assign w_cnt_cur = r_btb_cnt[w_u_idx];
  assign w_cnt_inc = (w_cnt_cur == 2'd3) ? 2'd3 : w_cnt_cur + 2'd1;
  assign w_cnt_dec = (w_cnt_cur == 2'd0) ? 2'd0 : w_cnt_cur - 2'd1;

  // Tag/target/counter storage is not reset; only the valid bits are.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btb_valid <= '0;
    end else if (w_u_en) begin
      if (w_u_hit) begin
        if (w_is_jal | w_is_jalr) begin
          r_btb_cnt[w_u_idx] <= 2'd3;
          r_btb_tgt[w_u_idx] <= w_target;
        end else if (w_is_br) begin
          if (bus.i_res_taken) begin
            r_btb_cnt[w_u_idx] <= w_cnt_inc;
            r_btb_tgt[w_u_idx] <= w_target;
          end else begin
            r_btb_cnt[w_u_idx] <= w_cnt_dec;
          end
        end else begin
          r_btb_valid[w_u_idx] <= 1'b0;
        end
      end else if (w_act_taken) begin
        r_btb_valid[w_u_idx] <= 1'b1;
        r_btb_tag[w_u_idx]   <= w_u_tag;
        r_btb_tgt[w_u_idx]   <= w_target;
        r_btb_cnt[w_u_idx]   <= (w_is_jal | w_is_jalr) ? 2'd3 : 2'd2;
      end
    end
  end
`else
  assign w_pred_taken  = 1'b0;
  assign w_pred_target = '0;
`endif

  assign bus.o_fetch_pc          = r_fetch_pc;
  assign bus.o_fetch_pred_taken  = w_pred_taken;
  assign bus.o_fetch_pred_target = w_pred_target;
  assign bus.o_redirect          = bus.i_trap_valid | w_redirect_res;
  assign bus.o_target_misalign   = w_misalign;
endmodule

// File: tb/tb_riscv_pc_gen.sv
// Directed bench for riscv_pc_gen; BTB scenarios follow RISCV_PC_BTB_EN like the design.
module tb_riscv_pc_gen;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  riscv_pc_gen_if #(.XLEN(32)) bus ();

  riscv_pc_gen #(.XLEN(32), .RESET_PC(32'h0), .BTB_ENTRIES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_stall           = 1'b0;
    bus.i_trap_valid      = 1'b0;
    bus.i_trap_vec        = '0;
    bus.i_res_valid       = 1'b0;
    bus.i_res_branch_op   = 3'b000;
    bus.i_res_taken       = 1'b0;
    bus.i_res_pc          = '0;
    bus.i_res_imm         = '0;
    bus.i_res_rs1         = '0;
    bus.i_res_pred_taken  = 1'b0;
    bus.i_res_pred_target = '0;
  endtask

  task automatic go_to(input logic [31:0] addr);
    idle();
    bus.i_trap_valid = 1'b1;
    bus.i_trap_vec   = addr;
    tick();
    idle();
  endtask

  task automatic resolve(input logic [2:0] op, input logic taken, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs1,
                         input logic ptaken, input logic [31:0] ptarget);
    bus.i_res_valid       = 1'b1;
    bus.i_res_branch_op   = op;
    bus.i_res_taken       = taken;
    bus.i_res_pc          = pc;
    bus.i_res_imm         = imm;
    bus.i_res_rs1         = rs1;
    bus.i_res_pred_taken  = ptaken;
    bus.i_res_pred_target = ptarget;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    n_total++; if (bus.o_fetch_pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", bus.o_fetch_pc, 32'h0); else n_pass++;
    n_total++; if (bus.o_fetch_pred_taken !== 1'b0) $display("FAIL reset_pred_taken: got %b want 0", bus.o_fetch_pred_taken); else n_pass++;
    n_total++; if (bus.o_fetch_pred_target !== 32'h0) $display("FAIL reset_pred_target: got %h want 0", bus.o_fetch_pred_target); else n_pass++;
    n_total++; if (bus.o_redirect !== 1'b0) $display("FAIL reset_redirect: got %b want 0", bus.o_redirect); else n_pass++;
    rst = 1'b0;
    #1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_total++;
      if (bus.o_fetch_pc !== 32'(i * 4)) $display("FAIL seq_step%0d: got %h want %h", i, bus.o_fetch_pc, 32'(i * 4));
      else n_pass++;
    end
  endtask

  task automatic test_stall_redirect();
    bus.i_stall = 1'b1;
    resolve(3'b001, 1'b0, 32'h10, 32'h20, 32'h0, 1'b0, 32'h0);
    n_total++; if (bus.o_redirect !== 1'b1) $display("FAIL stall_jal_redirect: got %b want 1", bus.o_redirect); else n_pass++;
    tick();
    n_total++; if (bus.o_fetch_pc !== 32'h30) $display("FAIL stall_jal_pc: got %h want %h", bus.o_fetch_pc, 32'h30); else n_pass++;
    bus.i_trap_valid = 1'b1;
    bus.i_trap_vec   = 32'h100;
    #1;
    n_total++; if (bus.o_redirect !== 1'b1) $display("FAIL trap_redirect: got %b want 1", bus.o_redirect); else n_pass++;
    tick();
    n_total++; if (bus.o_fetch_pc !== 32'h100) $display("FAIL trap_pc: got %h want %h", bus.o_fetch_pc, 32'h100); else n_pass++;
    idle();
    bus.i_stall = 1'b1;
    tick();
    n_total++; if (bus.o_fetch_pc !== 32'h100) $display("FAIL stall_hold: got %h want %h", bus.o_fetch_pc, 32'h100); else n_pass++;
    idle();
  endtask

  task automatic test_jalr_misalign();
    resolve(3'b010, 1'b0, 32'h20, 32'h2, 32'h1001, 1'b0, 32'h0);
    n_total++; if (bus.o_target_misalign !== 1'b1) $display("FAIL jalr_misalign_flag: got %b want 1", bus.o_target_misalign); else n_pass++;
    n_total++; if (bus.o_redirect !== 1'b0) $display("FAIL jalr_misalign_redirect: got %b want 0", bus.o_redirect); else n_pass++;
    tick();
    n_total++; if (bus.o_fetch_pc !== 32'h104) $display("FAIL jalr_misalign_pc: got %h want %h", bus.o_fetch_pc, 32'h104); else n_pass++;
    resolve(3'b010, 1'b0, 32'h20, 32'h3, 32'h1001, 1'b0, 32'h0);
    n_total++; if (bus.o_target_misalign !== 1'b0) $display("FAIL jalr_align_flag: got %b want 0", bus.o_target_misalign); else n_pass++;
    n_total++; if (bus.o_redirect !== 1'b1) $display("FAIL jalr_align_redirect: got %b want 1", bus.o_redirect); else n_pass++;
    tick();
    n_total++; if (bus.o_fetch_pc !== 32'h1004) $display("FAIL jalr_align_pc: got %h want %h", bus.o_fetch_pc, 32'h1004); else n_pass++;
    idle();
  endtask

  task automatic test_mispredict();
    resolve(3'b100, 1'b0, 32'h40, 32'h100, 32'h0, 1'b1, 32'h140);
    n_total++; if (bus.o_redirect !== 1'b1) $display("FAIL nt_mispredict_redirect: got %b want 1", bus.o_redirect); else n_pass++;
    tick();
    n_total++; if (bus.o_fetch_pc !== 32'h44) $display("FAIL nt_mispredict_pc: got %h want %h", bus.o_fetch_pc, 32'h44); else n_pass++;
    resolve(3'b001, 1'b0, 32'h304, 32'h10, 32'h0, 1'b1, 32'h318);
    n_total++; if (bus.o_redirect !== 1'b1) $display("FAIL wrong_target_redirect: got %b want 1", bus.o_redirect); else n_pass++;
    tick();
    n_total++; if (bus.o_fetch_pc !== 32'h314) $display("FAIL wrong_target_pc: got %h want %h", bus.o_fetch_pc, 32'h314); else n_pass++;
    idle();
    bus.i_res_branch_op = 3'b001;
    bus.i_res_imm       = 32'h2;
    bus.i_res_rs1       = 32'h1;
    #1;
    n_total++; if (bus.o_redirect !== 1'b0) $display("FAIL invalid_res_redirect: got %b want 0", bus.o_redirect); else n_pass++;
    n_total++; if (bus.o_target_misalign !== 1'b0) $display("FAIL invalid_res_misalign: got %b want 0", bus.o_target_misalign); else n_pass++;
    tick();
    n_total++; if (bus.o_fetch_pc !== 32'h318) $display("FAIL invalid_res_pc: got %h want %h", bus.o_fetch_pc, 32'h318); else n_pass++;
    idle();
  endtask

  task automatic test_wrap();
    go_to(32'hFFFF_FFFC);
    n_total++; if (bus.o_fetch_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_start: got %h want %h", bus.o_fetch_pc, 32'hFFFF_FFFC); else n_pass++;
    tick();
    n_total++; if (bus.o_fetch_pc !== 32'h0) $display("FAIL wrap_zero: got %h want 0", bus.o_fetch_pc); else n_pass++;
  endtask

`ifdef RISCV_PC_BTB_EN
  task automatic test_btb_learn();
    go_to(32'h80);
    n_total++; if (bus.o_fetch_pred_taken !== 1'b0) $display("FAIL btb_cold_pred: got %b want 0", bus.o_fetch_pred_taken); else n_pass++;
    resolve(3'b100, 1'b1, 32'h80, 32'h180, 32'h0, 1'b0, 32'h0);
    n_total++; if (bus.o_redirect !== 1'b1) $display("FAIL btb_first_redirect: got %b want 1", bus.o_redirect); else n_pass++;
    tick();
    idle();
    n_total++; if (bus.o_fetch_pc !== 32'h200) $display("FAIL btb_first_pc: got %h want %h", bus.o_fetch_pc, 32'h200); else n_pass++;
    n_total++; if (bus.o_fetch_pred_taken !== 1'b0) $display("FAIL btb_tag_mismatch: got %b want 0", bus.o_fetch_pred_taken); else n_pass++;
    go_to(32'h80);
    n_total++; if (bus.o_fetch_pred_taken !== 1'b1) $display("FAIL btb_learned_pred: got %b want 1", bus.o_fetch_pred_taken); else n_pass++;
    n_total++; if (bus.o_fetch_pred_target !== 32'h200) $display("FAIL btb_learned_target: got %h want %h", bus.o_fetch_pred_target, 32'h200); else n_pass++;
    n_total++; if (bus.o_redirect !== 1'b0) $display("FAIL btb_pred_no_redirect: got %b want 0", bus.o_redirect); else n_pass++;
    tick();
    n_total++; if (bus.o_fetch_pc !== 32'h200) $display("FAIL btb_pred_pc: got %h want %h", bus.o_fetch_pc, 32'h200); else n_pass++;
    resolve(3'b100, 1'b0, 32'h80, 32'h180, 32'h0, 1'b0, 32'h0);
    n_total++; if (bus.o_redirect !== 1'b0) $display("FAIL btb_nt1_redirect: got %b want 0", bus.o_redirect); else n_pass++;
    tick();
    resolve(3'b100, 1'b0, 32'h80, 32'h180, 32'h0, 1'b1, 32'h200);
    n_total++; if (bus.o_redirect !== 1'b1) $display("FAIL btb_nt2_redirect: got %b want 1", bus.o_redirect); else n_pass++;
    tick();
    n_total++; if (bus.o_fetch_pc !== 32'h84) $display("FAIL btb_nt2_pc: got %h want %h", bus.o_fetch_pc, 32'h84); else n_pass++;
    go_to(32'h80);
    n_total++; if (bus.o_fetch_pred_taken !== 1'b0) $display("FAIL btb_unlearned_pred: got %b want 0", bus.o_fetch_pred_taken); else n_pass++;
  endtask

  task automatic test_btb_alias();
    resolve(3'b001, 1'b0, 32'h80, 32'h180, 32'h0, 1'b0, 32'h0);
    n_total++; if (bus.o_fetch_pred_taken !== 1'b0) $display("FAIL btb_preupdate_lookup: got %b want 0", bus.o_fetch_pred_taken); else n_pass++;
    n_total++; if (bus.o_redirect !== 1'b1) $display("FAIL btb_jal_redirect: got %b want 1", bus.o_redirect); else n_pass++;
    tick();
    go_to(32'h80);
    n_total++; if (bus.o_fetch_pred_taken !== 1'b1) $display("FAIL btb_jal_pred: got %b want 1", bus.o_fetch_pred_taken); else n_pass++;
    resolve(3'b000, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1, 32'h200);
    n_total++; if (bus.o_redirect !== 1'b1) $display("FAIL btb_alias_redirect: got %b want 1", bus.o_redirect); else n_pass++;
    tick();
    n_total++; if (bus.o_fetch_pc !== 32'h84) $display("FAIL btb_alias_pc: got %h want %h", bus.o_fetch_pc, 32'h84); else n_pass++;
    go_to(32'h80);
    n_total++; if (bus.o_fetch_pred_taken !== 1'b0) $display("FAIL btb_alias_invalidated: got %b want 0", bus.o_fetch_pred_taken); else n_pass++;
  endtask
`else
  task automatic test_no_btb();
    go_to(32'h80);
    resolve(3'b100, 1'b1, 32'h80, 32'h180, 32'h0, 1'b0, 32'h0);
    n_total++; if (bus.o_redirect !== 1'b1) $display("FAIL nobtb_first_redirect: got %b want 1", bus.o_redirect); else n_pass++;
    tick();
    n_total++; if (bus.o_fetch_pc !== 32'h200) $display("FAIL nobtb_first_pc: got %h want %h", bus.o_fetch_pc, 32'h200); else n_pass++;
    go_to(32'h80);
    n_total++; if (bus.o_fetch_pred_taken !== 1'b0) $display("FAIL nobtb_pred_taken: got %b want 0", bus.o_fetch_pred_taken); else n_pass++;
    n_total++; if (bus.o_fetch_pred_target !== 32'h0) $display("FAIL nobtb_pred_target: got %h want 0", bus.o_fetch_pred_target); else n_pass++;
    resolve(3'b100, 1'b1, 32'h80, 32'h180, 32'h0, 1'b0, 32'h0);
    n_total++; if (bus.o_redirect !== 1'b1) $display("FAIL nobtb_second_redirect: got %b want 1", bus.o_redirect); else n_pass++;
    tick();
    idle();
    n_total++; if (bus.o_fetch_pc !== 32'h200) $display("FAIL nobtb_second_pc: got %h want %h", bus.o_fetch_pc, 32'h200); else n_pass++;
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    idle();
    test_reset();
    test_stall_redirect();
    test_jalr_misalign();
    test_mispredict();
    test_wrap();
`ifdef RISCV_PC_BTB_EN
    test_btb_learn();
    test_btb_alias();
`else
    test_no_btb();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
